// File: rtl/hwag_coil_pkg.sv
// Shared types for the HWAG coil scheduler: channel FSM states and the
// write-target select codes.
package hwag_coil_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SET = 2'd1,
        ST_CHARGE   = 2'd2
    } coil_state_e;

    localparam logic [1:0] SEL_IGN   = 2'd0;
    localparam logic [1:0] SEL_DWELL = 2'd1;
    localparam logic [1:0] SEL_OFS   = 2'd2;
    localparam logic [1:0] SEL_RSVD  = 2'd3;

endpackage

// File: rtl/hwag_coil_channel.sv
// One coil channel: phase-offset angle counter, staging/shadow angle registers
// and the IDLE / WAIT_SET / CHARGE sequencer driving a registered coil output.
module hwag_coil_channel
    import hwag_coil_pkg::*;
#(
    parameter int ACNT_WIDTH = 24,
    parameter int ACNT_MAX   = 3839
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  ena,
    input  logic                  hwag_start,
    input  logic                  ch_en,
    input  logic                  ign_we,
    input  logic                  dwell_we,
    input  logic                  ofs_we,
    input  logic [ACNT_WIDTH-1:0] wr_data,
    output logic                  coil_out,
    output logic                  fire,
    output logic [ACNT_WIDTH-1:0] acnt
);

    localparam logic [ACNT_WIDTH-1:0] MAX_L  = ACNT_WIDTH'(ACNT_MAX);
    localparam logic [ACNT_WIDTH-1:0] REV_L  = ACNT_WIDTH'(ACNT_MAX + 1);
    localparam logic [ACNT_WIDTH-1:0] ZERO_L = {ACNT_WIDTH{1'b0}};
    localparam logic [ACNT_WIDTH-1:0] ONE_L  = {{(ACNT_WIDTH-1){1'b0}}, 1'b1};

    // Charge start angle, folded back into one revolution when dwell spans the wrap.
    function automatic logic [ACNT_WIDTH-1:0] set_point(
        input logic [ACNT_WIDTH-1:0] ign,
        input logic [ACNT_WIDTH-1:0] dwell
    );
        if (ign < dwell) begin
            return ign - dwell + REV_L;
        end else begin
            return ign - dwell;
        end
    endfunction

    logic [ACNT_WIDTH-1:0] acnt_r, acnt_nxt_s;
    logic [ACNT_WIDTH-1:0] ign_stg_r, dwell_stg_r, ofs_stg_r;
    logic [ACNT_WIDTH-1:0] set_sh_r, rst_sh_r, dwell_sh_r;
    coil_state_e           state_r, state_nxt_s;
    logic                  tick_s, wrap_s, latch_s, fire_nxt_s;
    logic                  coil_r, fire_r;

    // Next counter value: reload offset while unsynchronised, else step on ticks.
    always_comb begin
        tick_s     = hwag_start & ena;
        wrap_s     = tick_s & (acnt_r == MAX_L);
        acnt_nxt_s = acnt_r;
        if (!hwag_start) begin
            acnt_nxt_s = ofs_stg_r;
        end else if (wrap_s) begin
            acnt_nxt_s = ZERO_L;
        end else if (tick_s) begin
            acnt_nxt_s = acnt_r + ONE_L;
        end else begin
            acnt_nxt_s = acnt_r;
        end
    end

    // Sequencer next state, fire request and shadow-latch decision.
    always_comb begin
        state_nxt_s = state_r;
        fire_nxt_s  = 1'b0;
        if (!hwag_start || !ch_en) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_WAIT_SET;
                end
                ST_WAIT_SET: begin
                    if (tick_s && (acnt_nxt_s == set_sh_r) && (dwell_sh_r != ZERO_L)) begin
                        state_nxt_s = ST_CHARGE;
                    end else begin
                        state_nxt_s = ST_WAIT_SET;
                    end
                end
                ST_CHARGE: begin
                    if (tick_s && (acnt_nxt_s == rst_sh_r)) begin
                        state_nxt_s = ST_WAIT_SET;
                        fire_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_CHARGE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
        // Shadows never move under a running charge, so a pulse always ends where it was scheduled.
        latch_s = (state_nxt_s == ST_IDLE)
                | (wrap_s & (state_r != ST_CHARGE))
                | ((state_r == ST_CHARGE) & (state_nxt_s == ST_WAIT_SET));
    end

    // Angle counter, staging and shadow registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acnt_r      <= ZERO_L;
            ign_stg_r   <= ZERO_L;
            dwell_stg_r <= ZERO_L;
            ofs_stg_r   <= ZERO_L;
            set_sh_r    <= ZERO_L;
            rst_sh_r    <= ZERO_L;
            dwell_sh_r  <= ZERO_L;
        end else begin
            acnt_r <= acnt_nxt_s;
            if (ign_we)   ign_stg_r   <= wr_data;
            if (dwell_we) dwell_stg_r <= wr_data;
            if (ofs_we)   ofs_stg_r   <= wr_data;
            if (latch_s) begin
                set_sh_r   <= set_point(ign_stg_r, dwell_stg_r);
                rst_sh_r   <= ign_stg_r;
                dwell_sh_r <= dwell_stg_r;
            end
        end
    end

    // State register and registered coil/fire drive.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
            coil_r  <= 1'b0;
            fire_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            coil_r  <= (state_nxt_s == ST_CHARGE);
            fire_r  <= fire_nxt_s;
        end
    end

    assign coil_out = coil_r;
    assign fire     = fire_r;
    assign acnt     = acnt_r;

endmodule

// File: rtl/hwag_coil_sched.sv
// Multi-channel coil scheduler: register write decode with rejection flag and
// CH_NUM independent coil channels.
module hwag_coil_sched
    import hwag_coil_pkg::*;
#(
    parameter int CH_NUM     = 4,
    parameter int ACNT_WIDTH = 24,
    parameter int ACNT_MAX   = 3839,
    localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         ena,
    input  logic                         hwag_start,
    input  logic [CH_NUM-1:0]            ch_en,
    input  logic                         wr_en,
    input  logic [CH_W-1:0]              wr_ch,
    input  logic [1:0]                   wr_sel,
    input  logic [ACNT_WIDTH-1:0]        wr_data,
    output logic                         wr_err,
    output logic [CH_NUM-1:0]            coil_out,
    output logic [CH_NUM-1:0]            fire,
    output logic [CH_NUM*ACNT_WIDTH-1:0] acnt_out
);

    localparam logic [CH_W:0]           CH_LIM_L = (CH_W + 1)'(CH_NUM);
    localparam logic [ACNT_WIDTH-1:0]   MAX_L    = ACNT_WIDTH'(ACNT_MAX);

    logic wr_acc_s, wr_rej_s, wr_err_r;

    // Accept only in-range channel, defined target and an angle inside one revolution.
    always_comb begin
        wr_acc_s = wr_en & ({1'b0, wr_ch} < CH_LIM_L) & (wr_sel != SEL_RSVD) & (wr_data <= MAX_L);
        wr_rej_s = wr_en & ~wr_acc_s;
    end

    // Rejected-write flag, one cycle after the offending strobe.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_err_r <= 1'b0;
        end else begin
            wr_err_r <= wr_rej_s;
        end
    end

    assign wr_err = wr_err_r;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic hit_s;
        assign hit_s = wr_acc_s & (wr_ch == CH_W'(i));

        hwag_coil_channel #(
            .ACNT_WIDTH (ACNT_WIDTH),
            .ACNT_MAX   (ACNT_MAX)
        ) u_ch (
            .clk        (clk),
            .nrst       (nrst),
            .ena        (ena),
            .hwag_start (hwag_start),
            .ch_en      (ch_en[i]),
            .ign_we     (hit_s & (wr_sel == SEL_IGN)),
            .dwell_we   (hit_s & (wr_sel == SEL_DWELL)),
            .ofs_we     (hit_s & (wr_sel == SEL_OFS)),
            .wr_data    (wr_data),
            .coil_out   (coil_out[i]),
            .fire       (fire[i]),
            .acnt       (acnt_out[i*ACNT_WIDTH +: ACNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_hwag_coil_sched.sv
// Directed self-checking bench for hwag_coil_sched (two-channel main instance,
// plus a three-channel instance to reach an out-of-range write channel).
module tb_hwag_coil_sched;

    localparam int W   = 24;
    localparam int MAX = 3839;
    localparam int REV = MAX + 1;

    logic          clk = 1'b0;
    logic          nrst, ena, hwag_start;
    logic [1:0]    ch_en;
    logic          wr_en;
    logic [0:0]    wr_ch;
    logic [1:0]    wr_sel;
    logic [W-1:0]  wr_data;
    logic          wr_err;
    logic [1:0]    coil_out, fire;
    logic [2*W-1:0] acnt_out;

    logic          w3_en;
    logic [1:0]    w3_ch;
    logic [1:0]    w3_sel;
    logic [W-1:0]  w3_data;
    logic          w3_err;
    logic [2:0]    w3_coil, w3_fire;
    logic [3*W-1:0] w3_acnt;

    int checks = 0;
    int errors = 0;

    hwag_coil_sched #(.CH_NUM(2), .ACNT_WIDTH(W), .ACNT_MAX(MAX)) dut (
        .clk(clk), .nrst(nrst), .ena(ena), .hwag_start(hwag_start), .ch_en(ch_en),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel), .wr_data(wr_data),
        .wr_err(wr_err), .coil_out(coil_out), .fire(fire), .acnt_out(acnt_out)
    );

    hwag_coil_sched #(.CH_NUM(3), .ACNT_WIDTH(W), .ACNT_MAX(MAX)) dut3 (
        .clk(clk), .nrst(nrst), .ena(ena), .hwag_start(hwag_start), .ch_en(3'b000),
        .wr_en(w3_en), .wr_ch(w3_ch), .wr_sel(w3_sel), .wr_data(w3_data),
        .wr_err(w3_err), .coil_out(w3_coil), .fire(w3_fire), .acnt_out(w3_acnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int sel, input int data);
        wr_en   = 1'b1;
        wr_ch   = 1'(ch);
        wr_sel  = 2'(sel);
        wr_data = W'(data);
        step();
        wr_en   = 1'b0;
    endtask

    function automatic logic in_win(input int c, input int s, input int r);
        if (s < r) return (c >= s) && (c < r);
        else       return (c >= s) || (c < r);
    endfunction

    function automatic int acnt_of(input int ch);
        return int'(acnt_out[ch*W +: W]);
    endfunction

    // Runs with ena every cycle, checking counters, coil windows and fire pulses against a model.
    task automatic run_win(input string name, input int ncyc, input int ofs0, input int ofs1,
                           input int set0, input int rst0, input int set1, input int rst1,
                           input int nf0, input int nf1);
        int cnt[2];
        int st[2];
        int rs[2];
        int nf[2];
        int bad;
        cnt[0] = ofs0; cnt[1] = ofs1;
        st[0] = set0;  st[1] = set1;
        rs[0] = rst0;  rs[1] = rst1;
        nf[0] = 0;     nf[1] = 0;
        bad = 0;
        hwag_start = 1'b1;
        ena = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            step();
            for (int c = 0; c < 2; c++) begin
                cnt[c] = (cnt[c] == MAX) ? 0 : cnt[c] + 1;
                if (acnt_of(c) != cnt[c]) bad++;
                if (coil_out[c] !== in_win(cnt[c], st[c], rs[c])) bad++;
                if (fire[c] !== (cnt[c] == rs[c])) bad++;
                if (fire[c] === 1'b1) nf[c]++;
            end
        end
        hwag_start = 1'b0;
        step();
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s_window: %0d bad cycles, want 0", name, bad);
        end
        checks++;
        if (nf[0] !== nf0 || nf[1] !== nf1) begin
            errors++;
            $display("FAIL %s_fires: got %0d/%0d, want %0d/%0d", name, nf[0], nf[1], nf0, nf1);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (coil_out !== 2'b00 || fire !== 2'b00 || wr_err !== 1'b0 || w3_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: coil=%b fire=%b err=%b, want 00 00 0", coil_out, fire, wr_err);
        end
        checks++;
        if (acnt_out !== '0) begin
            errors++;
            $display("FAIL reset_acnt: got %h, want 0", acnt_out);
        end
    endtask

    task automatic test_write_err();
        wr(0, 2, 2752);
        checks++;
        if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_ok_err: got %b, want 0", wr_err); end
        wr(1, 2, 832);
        step();
        checks++;
        if (acnt_of(0) != 2752 || acnt_of(1) != 832) begin
            errors++;
            $display("FAIL ofs_load: got %0d/%0d, want 2752/832", acnt_of(0), acnt_of(1));
        end
        wr(0, 2, 3840);
        checks++;
        if (wr_err !== 1'b1) begin errors++; $display("FAIL err_data: got %b, want 1", wr_err); end
        step();
        checks++;
        if (wr_err !== 1'b0 || acnt_of(0) != 2752) begin
            errors++;
            $display("FAIL err_data_after: err=%b acnt0=%0d, want 0/2752", wr_err, acnt_of(0));
        end
        wr(1, 3, 5);
        checks++;
        if (wr_err !== 1'b1) begin errors++; $display("FAIL err_sel3: got %b, want 1", wr_err); end
        step();
        checks++;
        if (acnt_of(0) != 2752 || acnt_of(1) != 832) begin
            errors++;
            $display("FAIL err_sel3_after: got %0d/%0d, want 2752/832", acnt_of(0), acnt_of(1));
        end
        wr(0, 0, MAX);
        checks++;
        if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_max_ok: got %b, want 0", wr_err); end
        w3_en = 1'b1; w3_ch = 2'd3; w3_sel = 2'd0; w3_data = W'(5);
        step();
        checks++;
        if (w3_err !== 1'b1) begin errors++; $display("FAIL err_ch: got %b, want 1", w3_err); end
        w3_ch = 2'd2;
        step();
        w3_en = 1'b0;
        checks++;
        if (w3_err !== 1'b0) begin errors++; $display("FAIL ch2_ok: got %b, want 0", w3_err); end
    endtask

    task automatic test_basic();
        wr(0, 0, 100); wr(0, 1, 50); wr(1, 0, 100); wr(1, 1, 50);
        ch_en = 2'b11;
        step();
        run_win("basic", 2 * REV, 2752, 832, 50, 100, 50, 100, 2, 2);
    endtask

    task automatic test_wrap();
        wr(0, 2, 3700); wr(0, 0, 20);
        step();
        run_win("wrap", REV, 3700, 832, 3810, 20, 50, 100, 1, 1);
    endtask

    task automatic test_update_in_charge();
        int cnt;
        int phase;
        int nf;
        int bad;
        wr(0, 2, 0); wr(0, 0, 100);
        step();
        cnt = 0; phase = 0; nf = 0; bad = 0;
        hwag_start = 1'b1;
        ena = 1'b1;
        for (int i = 0; i < 260; i++) begin
            if (cnt == 60) begin
                wr_en = 1'b1; wr_ch = 1'b0; wr_sel = 2'd0; wr_data = W'(200);
            end else begin
                wr_en = 1'b0;
            end
            step();
            cnt++;
            if (acnt_of(0) != cnt) bad++;
            if (coil_out[0] !== in_win(cnt, phase ? 150 : 50, phase ? 200 : 100)) bad++;
            if (fire[0] !== (cnt == (phase ? 200 : 100))) bad++;
            if (fire[0] === 1'b1) begin nf++; phase = 1; end
        end
        wr_en = 1'b0;
        hwag_start = 1'b0;
        step();
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL update_window: %0d bad cycles, want 0", bad); end
        checks++;
        if (nf !== 2) begin errors++; $display("FAIL update_fires: got %0d, want 2", nf); end
    endtask

    task automatic test_start_drop();
        int nf;
        wr(0, 0, 100);
        step();
        hwag_start = 1'b1;
        ena = 1'b1;
        for (int i = 0; i < 70; i++) step();
        checks++;
        if (coil_out[0] !== 1'b1 || acnt_of(0) != 70) begin
            errors++;
            $display("FAIL drop_pre: coil=%b acnt=%0d, want 1/70", coil_out[0], acnt_of(0));
        end
        hwag_start = 1'b0;
        step();
        checks++;
        if (coil_out !== 2'b00 || fire !== 2'b00 || acnt_of(0) != 0 || acnt_of(1) != 832) begin
            errors++;
            $display("FAIL drop_post: coil=%b fire=%b acnt=%0d/%0d, want 00 00 0/832",
                     coil_out, fire, acnt_of(0), acnt_of(1));
        end
        nf = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (fire !== 2'b00) nf++;
        end
        checks++;
        if (nf !== 0) begin errors++; $display("FAIL drop_nofire: got %0d, want 0", nf); end
    endtask

    task automatic test_reset_mid();
        int cnt;
        int wrapped;
        int bad;
        int nf;
        hwag_start = 1'b1;
        ena = 1'b1;
        for (int i = 0; i < 70; i++) step();
        checks++;
        if (coil_out[0] !== 1'b1) begin errors++; $display("FAIL rmid_pre: coil=%b, want 1", coil_out[0]); end
        nrst = 1'b0;
        #1;
        checks++;
        if (coil_out !== 2'b00 || fire !== 2'b00 || acnt_out !== '0) begin
            errors++;
            $display("FAIL rmid_async: coil=%b fire=%b acnt=%h, want 00 00 0", coil_out, fire, acnt_out);
        end
        step();
        nrst = 1'b1;
        cnt = 0; wrapped = 0; bad = 0; nf = 0;
        for (int i = 0; i < 2 * REV; i++) begin
            if (i == 10) begin
                wr_en = 1'b1; wr_ch = 1'b0; wr_sel = 2'd0; wr_data = W'(100);
            end else if (i == 11) begin
                wr_en = 1'b1; wr_ch = 1'b0; wr_sel = 2'd1; wr_data = W'(50);
            end else begin
                wr_en = 1'b0;
            end
            step();
            cnt = (cnt == MAX) ? 0 : cnt + 1;
            if (cnt == 0) wrapped = 1;
            if (acnt_of(0) != cnt) bad++;
            if (coil_out[0] !== (wrapped == 1 && in_win(cnt, 50, 100))) bad++;
            if (fire[0] !== (wrapped == 1 && cnt == 100)) bad++;
            if (coil_out[1] !== 1'b0 || fire[1] !== 1'b0) bad++;
            if (fire[0] === 1'b1) nf++;
        end
        hwag_start = 1'b0;
        step();
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rmid_window: %0d bad cycles, want 0", bad); end
        checks++;
        if (nf !== 1) begin errors++; $display("FAIL rmid_fires: got %0d, want 1", nf); end
    endtask

    initial begin
        nrst = 1'b0; ena = 1'b0; hwag_start = 1'b0; ch_en = 2'b00;
        wr_en = 1'b0; wr_ch = 1'b0; wr_sel = 2'd0; wr_data = '0;
        w3_en = 1'b0; w3_ch = 2'd0; w3_sel = 2'd0; w3_data = '0;
        step();
        step();
        test_reset();
        nrst = 1'b1;
        step();
        test_write_err();
        test_basic();
        test_wrap();
        test_update_in_charge();
        test_start_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
